// File: rtl/tristate_bus_tx.sv
// Serializer feeding an inverting single-wire tristate buffer: frames a word as
// start, LSB-first data, optional parity and stop bits, then releases the bus.
module tristate_bus_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int TURNAROUND = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txValid,
    output logic                  txReady,
    output logic                  busDataN,
    output logic                  busEnable,
    output logic                  txBusy,
    output logic                  txDone
);

    localparam int CNT_MAX = (BIT_CYCLES > TURNAROUND) ? BIT_CYCLES : TURNAROUND;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_TURN
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cyc, cyc_nxt;
    logic [BW-1:0]         bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic                  par, par_nxt;
    logic                  ready_nxt, en_nxt, dn_nxt, done_nxt;
    logic                  bit_end;

    assign bit_end = (cyc == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cyc       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            txReady   <= 1'b1;
            busEnable <= 1'b0;
            busDataN  <= 1'b1;
            txBusy    <= 1'b0;
            txDone    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cyc       <= cyc_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            par       <= par_nxt;
            txReady   <= ready_nxt;
            busEnable <= en_nxt;
            busDataN  <= dn_nxt;
            txBusy    <= ~ready_nxt;
            txDone    <= done_nxt;
        end
    end

    // Outputs are computed one cycle ahead so each register holds the level for the
    // state being entered; busDataN always carries the complement of the wire bit.
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par;
        ready_nxt = txReady;
        en_nxt    = busEnable;
        dn_nxt    = busDataN;
        done_nxt  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (txValid) begin
                    state_nxt = S_START;
                    shreg_nxt = txData;
                    par_nxt   = (^txData) ^ ODD;
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                    ready_nxt = 1'b0;
                    en_nxt    = 1'b1;
                    dn_nxt    = 1'b1;
                end
            end
            S_START: begin
                cyc_nxt = bit_end ? '0 : cyc + CW'(1);
                if (bit_end) begin
                    state_nxt = S_DATA;
                    dn_nxt    = ~shreg[0];
                end
            end
            S_DATA: begin
                cyc_nxt = bit_end ? '0 : cyc + CW'(1);
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        dn_nxt    = (PARITY_EN != 0) ? ~par : 1'b0;
                    end else begin
                        bit_nxt   = bit_cnt + BW'(1);
                        shreg_nxt = shreg >> 1;
                        dn_nxt    = ~shreg_nxt[0];
                    end
                end
            end
            S_PARITY: begin
                cyc_nxt = bit_end ? '0 : cyc + CW'(1);
                if (bit_end) begin
                    state_nxt = S_STOP;
                    dn_nxt    = 1'b0;
                end
            end
            S_STOP: begin
                cyc_nxt = bit_end ? '0 : cyc + CW'(1);
                if (bit_end) begin
                    en_nxt   = 1'b0;
                    dn_nxt   = 1'b1;
                    done_nxt = 1'b1;
                    if (TURNAROUND == 0) begin
                        state_nxt = S_IDLE;
                        ready_nxt = 1'b1;
                    end else begin
                        state_nxt = S_TURN;
                    end
                end
            end
            S_TURN: begin
                if (cyc == TURN_LAST) begin
                    cyc_nxt   = '0;
                    state_nxt = S_IDLE;
                    ready_nxt = 1'b1;
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                ready_nxt = 1'b1;
                en_nxt    = 1'b0;
                dn_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_tristate_bus_tx.sv
// Bench for tristate_bus_tx: four parameter variants share one stimulus stream and are
// checked every cycle against a frame-timeline model built from bit lists.
module tb_tristate_bus_tx;

    localparam int ND = 4;
    localparam int P_DW [ND] = '{8, 8, 8, 1};
    localparam int P_BC [ND] = '{4, 4, 4, 1};
    localparam int P_PE [ND] = '{1, 1, 0, 1};
    localparam int P_PO [ND] = '{0, 1, 0, 0};
    localparam int P_T  [ND] = '{2, 2, 2, 0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [7:0]    tx_data = '0;
    logic [ND-1:0] rdy, dn, en, busy, done;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    int   pos [ND];
    int   nb  [ND];
    logic bits[ND][12];
    int   en_cnt  [ND];
    int   done_cnt[ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        tristate_bus_tx #(
            .DATA_WIDTH(P_DW[g]),
            .BIT_CYCLES(P_BC[g]),
            .PARITY_EN (P_PE[g]),
            .PARITY_ODD(P_PO[g]),
            .TURNAROUND(P_T[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .txData   (tx_data[P_DW[g]-1:0]),
            .txValid  (tx_valid),
            .txReady  (rdy[g]),
            .busDataN (dn[g]),
            .busEnable(en[g]),
            .txBusy   (busy[g]),
            .txDone   (done[g])
        );
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {busEnable, busDataN, txReady, txBusy, txDone} from the position in the frame timeline:
    // wire bits for nb*BC cycles, TURNAROUND released cycles, then one released cycle with ready.
    function automatic logic [4:0] expect_out(input int d);
        int f, k;
        f = nb[d] * P_BC[d];
        if (pos[d] < 0) return 5'b01100;
        if (pos[d] < f) return {1'b1, ~bits[d][pos[d] / P_BC[d]], 3'b010};
        k = pos[d] - f;
        if (k < P_T[d]) return {4'b0101, k == 0};
        return {4'b0110, P_T[d] == 0};
    endfunction

    task automatic model_edge();
        for (int unsigned d = 0; d < ND; d++) begin
            logic [4:0] e;
            logic       p;
            e = expect_out(d);
            if (rst) begin
                pos[d] = -1;
            end else if (e[2] && tx_valid) begin
                pos[d] = 0;
                nb[d]  = 0;
                p      = (P_PO[d] != 0);
                bits[d][nb[d]++] = 1'b0;
                for (int unsigned i = 0; i < P_DW[d]; i++) begin
                    bits[d][nb[d]++] = tx_data[i];
                    p ^= tx_data[i];
                end
                if (P_PE[d] != 0) bits[d][nb[d]++] = p;
                bits[d][nb[d]++] = 1'b1;
            end else if (pos[d] >= 0) begin
                pos[d]++;
                if (pos[d] > nb[d] * P_BC[d] + P_T[d]) pos[d] = -1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
        for (int unsigned d = 0; d < ND; d++) begin
            cmp($sformatf("dut%0d_cyc%0d", d, cycle),
                {27'd0, en[d], dn[d], rdy[d], busy[d], done[d]}, {27'd0, expect_out(d)});
            if (en[d] === 1'b1) en_cnt[d]++;
            if (done[d] === 1'b1) done_cnt[d]++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        for (int unsigned d = 0; d < ND; d++) begin
            en_cnt[d]   = 0;
            done_cnt[d] = 0;
        end
    endtask

    task automatic single_frame(input logic [7:0] w, input string name,
                                input int exp_en0, input int exp_en2);
        clear_counts();
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        steps(59);
        cmp({name, "_en_cycles_dflt"}, en_cnt[0], exp_en0);
        cmp({name, "_en_cycles_odd"},  en_cnt[1], exp_en0);
        cmp({name, "_en_cycles_nopar"}, en_cnt[2], exp_en2);
        cmp({name, "_en_cycles_edge"}, en_cnt[3], 4);
        for (int unsigned d = 0; d < ND; d++)
            cmp($sformatf("%s_done_count_dut%0d", name, d), done_cnt[d], 1);
    endtask

    initial begin
        for (int unsigned d = 0; d < ND; d++) begin
            pos[d] = -1;
            nb[d]  = 0;
        end

        rst = 1'b1;
        steps(3);
        rst = 1'b0;
        steps(10);

        single_frame(8'hA5, "a5", 44, 40);
        single_frame(8'h01, "x01", 44, 40);
        single_frame(8'hFF, "xff", 44, 40);

        // Back-to-back with valid held high; data scrambled while frames are in flight.
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hC3;
        steps(50);
        for (int i = 0; i < 60; i++) begin
            tx_data = 8'($urandom);
            step();
        end
        tx_valid = 1'b0;
        steps(60);

        // Reset during data bit 4 of 0x55 on the default instance.
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        steps(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("rst_mid_en_released", {31'd0, en[0]}, 32'd0);
        steps(5);
        single_frame(8'h0F, "x0f", 44, 40);

        for (int i = 0; i < 600; i++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            step();
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        steps(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
